scatter_responder: RTL

Processor-side counterpart of the coprocessor's main control unit scatter protocol. Accepts the (row, column) block indexes offered one processor at a time on the one-hot `Indexes_Ready` vector, acknowledges each offer, latches the indexes into per-processor lanes and starts the matching core. It then collects per-core completion and returns a single `Result_Ready` pulse per scatter round. It sits between the main control unit and the array of `P` processing cores.

---
 rtl/scatter_pkg.sv | 9 +
 rtl/scatter_lane.sv | 33 +++
 rtl/scatter_responder.sv | 74 +++++++
 3 files changed

// File: rtl/scatter_pkg.sv
// scatter_pkg: state encodings, one-hot helper and default sizes shared with the main control unit
package scatter_pkg;
  typedef enum logic [1:0] {S_COLLECT, S_ACK, S_WAIT_DONE, S_REPORT} state_t;
  localparam int P_DEFAULT = 4;
  localparam int INDEX_WIDTH_DEFAULT = 8;
  function automatic logic is_one_hot(input logic [31:0] v);
    return v != '0 && (v & (v - 32'd1)) == '0;
  endfunction
endpackage

// File: rtl/scatter_lane.sv
// scatter_lane: per-lane index registers, start pulse and accepted/done round bits
module scatter_lane #(
  parameter int W = 8
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         load,
  input  logic         clear,
  input  logic         core_done,
  input  logic [W-1:0] next_row,
  input  logic [W-1:0] next_column,
  output logic [W-1:0] row,
  output logic [W-1:0] column,
  output logic         start,
  output logic         accepted,
  output logic         done
);
  // latch indexes on accept, pulse start, track round membership and completion
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      row <= '0;
      column <= '0;
      start <= 1'b0;
      accepted <= 1'b0;
      done <= 1'b0;
    end else begin
      row <= load ? next_row : row;
      column <= load ? next_column : column;
      start <= load;
      accepted <= clear ? 1'b0 : accepted | load;
      done <= clear ? 1'b0 : done | (core_done & accepted);
    end
endmodule

// File: rtl/scatter_responder.sv
// scatter_responder: accepts one-hot scattered index offers, starts cores, reports round completion
module scatter_responder
  import scatter_pkg::*;
#(
  parameter int P = P_DEFAULT,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic [INDEX_WIDTH-1:0]   i_Row_Index,
  input  logic [INDEX_WIDTH-1:0]   i_Column_Index,
  input  logic [P-1:0]             i_Indexes_Ready,
  output logic                     o_Indexes_Received,
  output logic                     o_Result_Ready,
  output logic [P*INDEX_WIDTH-1:0] o_Core_Row,
  output logic [P*INDEX_WIDTH-1:0] o_Core_Column,
  output logic [P-1:0]             o_Core_Start,
  input  logic [P-1:0]             i_Core_Done,
  output logic                     o_Error
);
  state_t state, state_next;
  logic [P-1:0] accepted, done, load;
  logic one_hot, all_done, offer, clear, fault;
  assign one_hot = is_one_hot(32'(i_Indexes_Ready));
  assign all_done = ((done | i_Core_Done) & accepted) == accepted;
  assign load = offer ? i_Indexes_Ready : '0;
  // state register
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) state <= S_COLLECT;
    else state <= state_next;
  // next-state: accept -> ack -> collect, close on empty select, report once all accepted lanes are done
  always_comb begin
    state_next = state;
    case (state)
      S_COLLECT:   state_next = offer ? S_ACK : (i_Indexes_Ready == '0 && accepted != '0) ? S_WAIT_DONE : S_COLLECT;
      S_ACK:       state_next = S_COLLECT;
      S_WAIT_DONE: state_next = all_done ? S_REPORT : S_WAIT_DONE;
      default:     state_next = S_COLLECT;
    endcase
  end
  // decoded actions: new-lane offer, round completion and protocol faults
  always_comb begin
    offer = state == S_COLLECT && one_hot && (i_Indexes_Ready & accepted) == '0;
    clear = state == S_WAIT_DONE && all_done;
    fault = (state == S_COLLECT && i_Indexes_Ready != '0 && !one_hot) || (i_Core_Done & ~accepted) != '0;
  end
  // registered acknowledge, result pulse and sticky error
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      o_Indexes_Received <= 1'b0;
      o_Result_Ready <= 1'b0;
      o_Error <= 1'b0;
    end else begin
      o_Indexes_Received <= offer;
      o_Result_Ready <= clear;
      o_Error <= o_Error | fault;
    end
  for (genvar i = 0; i < P; i++) begin : g_lane
    scatter_lane #(.W(INDEX_WIDTH)) u_lane (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .load        (load[i]),
      .clear       (clear),
      .core_done   (i_Core_Done[i]),
      .next_row    (i_Row_Index),
      .next_column (i_Column_Index),
      .row         (o_Core_Row[i*INDEX_WIDTH +: INDEX_WIDTH]),
      .column      (o_Core_Column[i*INDEX_WIDTH +: INDEX_WIDTH]),
      .start       (o_Core_Start[i]),
      .accepted    (accepted[i]),
      .done        (done[i])
    );
  end
endmodule
